// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: widths, legal prescale
// values, state type and the 3-sample majority helper.
package uart_rx_pkg;

  localparam int PRESCALE_W = 6;
  localparam int BIT_CNT_W  = 4;

  localparam int PRESC_8   = 8;
  localparam int PRESC_16  = 16;
  localparam int PRESC_32  = 32;
  localparam int PRESC_MIN = PRESC_8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } smp_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage : uart_rx_pkg

// File: rtl/bit_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a
// configurable reset value so idle-high lines come out of reset quiet.
module bit_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : bit_sync_2ff

// File: rtl/data_sampler_rx.sv
// UART RX bit-timing front end: line synchroniser, edge/bit counters and
// 3-sample majority vote around each bit centre.
module data_sampler_rx
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = uart_rx_pkg::PRESCALE_W,
  parameter int BIT_CNT_W  = uart_rx_pkg::BIT_CNT_W
) (
  input  logic                  CLK_smp,
  input  logic                  RST_smp,
  input  logic                  RX_IN_smp,
  input  logic                  cnt_en,
  input  logic [PRESCALE_W-1:0] prescale_FSM,
  output logic                  rx_sync,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  sample_bit_deser,
  output logic                  sample_valid
);

  localparam int CW = PRESCALE_W + 1;

  smp_state_e            state_q;
  logic [PRESCALE_W-1:0] p_q;
  logic [PRESCALE_W-1:0] edge_q;
  logic [BIT_CNT_W-1:0]  bit_q;
  logic                  s0_q;
  logic                  s1_q;
  logic                  smp_q;
  logic                  vld_q;

  logic                  rx_sync_w;
  logic [PRESCALE_W-1:0] p_in_d;
  logic [CW-1:0]         edge_ext;
  logic [CW-1:0]         half_c;
  logic [CW-1:0]         half_m1_c;
  logic [CW-1:0]         half_p1_c;
  logic [CW-1:0]         last_c;

  bit_sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk_i (CLK_smp),
    .rst_i (RST_smp),
    .d_i   (RX_IN_smp),
    .q_o   (rx_sync_w)
  );

  // Compare points are formed one bit wider than the counter so P-1 and
  // H+1 never wrap at the largest prescale.
  always_comb begin
    p_in_d    = (prescale_FSM < PRESCALE_W'(PRESC_MIN)) ? PRESCALE_W'(PRESC_MIN)
                                                        : prescale_FSM;
    edge_ext  = {1'b0, edge_q};
    half_c    = {1'b0, p_q} >> 1;
    half_m1_c = half_c - CW'(1);
    half_p1_c = half_c + CW'(1);
    last_c    = {1'b0, p_q} - CW'(1);
  end

  always_ff @(posedge CLK_smp or posedge RST_smp) begin
    if (RST_smp) begin
      state_q <= ST_IDLE;
      p_q     <= PRESCALE_W'(PRESC_MIN);
      edge_q  <= '0;
      bit_q   <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      smp_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          edge_q <= '0;
          bit_q  <= '0;
          if (cnt_en) begin
            state_q <= ST_COUNT;
            p_q     <= p_in_d;
          end
        end
        ST_COUNT: begin
          if (!cnt_en) begin
            state_q <= ST_IDLE;
            edge_q  <= '0;
            bit_q   <= '0;
          end else begin
            if (edge_ext == last_c) begin
              edge_q <= '0;
              if (bit_q != {BIT_CNT_W{1'b1}}) bit_q <= bit_q + 1'b1;
            end else begin
              edge_q <= edge_q + 1'b1;
            end
            if (edge_ext == half_m1_c) s0_q <= rx_sync_w;
            if (edge_ext == half_c)    s1_q <= rx_sync_w;
            if (edge_ext == half_p1_c) begin
              smp_q <= maj3(s0_q, s1_q, rx_sync_w);
              vld_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_sync          = rx_sync_w;
  assign edge_cnt         = edge_q;
  assign bit_cnt          = bit_q;
  assign sample_bit_deser = smp_q;
  assign sample_valid     = vld_q;

endmodule : data_sampler_rx

// File: tb/tb_data_sampler_rx.sv
// Bench for data_sampler_rx: directed frames plus random frames checked
// cycle by cycle against a frame-position reference model.
module tb_data_sampler_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       cnt_en;
  logic [5:0] prescale;
  logic       rx_sync;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       smp_bit;
  logic       smp_vld;

  int n_tests = 0;
  int n_fail  = 0;

  data_sampler_rx dut (
    .CLK_smp          (clk),
    .RST_smp          (rst),
    .RX_IN_smp        (rx_in),
    .cnt_en           (cnt_en),
    .prescale_FSM     (prescale),
    .rx_sync          (rx_sync),
    .edge_cnt         (edge_cnt),
    .bit_cnt          (bit_cnt),
    .sample_bit_deser (smp_bit),
    .sample_valid     (smp_vld)
  );

  always #5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: position in frame as a cycle count k since frame start.
  logic m_s1, m_sync, m_bit, m_valid, m_active;
  int   m_k, m_P;
  int   m_samp [3];

  // Observation log for the directed checks.
  logic obs_q [$];
  int   last_vld_edge, max_edge, max_bit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b1; m_sync = 1'b1; m_bit = 1'b1; m_valid = 1'b0;
    m_active = 1'b0; m_k = 0; m_P = 8;
    for (int i = 0; i < 3; i++) m_samp[i] = 1;
  endtask

  function automatic int clamp_p(input logic [5:0] ps);
    return (ps < 6'd8) ? 8 : int'(ps);
  endfunction

  task automatic model_edge(input logic rx, input logic en, input logic [5:0] ps);
    logic new_sync;
    int   h, e;
    new_sync = m_s1;
    m_s1     = rx;
    m_valid  = 1'b0;
    if (!m_active) begin
      if (en) begin
        m_active = 1'b1;
        m_P      = clamp_p(ps);
        m_k      = 0;
      end
    end else if (!en) begin
      m_active = 1'b0;
    end else begin
      m_k++;
      h = m_P / 2;
      if (m_k % m_P == h + 2) begin
        m_valid = 1'b1;
        m_bit   = ((m_samp[0] + m_samp[1] + m_samp[2]) >= 2);
      end
    end
    m_sync = new_sync;
    if (m_active) begin
      h = m_P / 2;
      e = m_k % m_P;
      if (e >= h - 1 && e <= h + 1) m_samp[e - (h - 1)] = int'(m_sync);
    end
  endtask

  task automatic check_outputs();
    int exp_edge, exp_bit;
    exp_edge = m_active ? (m_k % m_P) : 0;
    exp_bit  = m_active ? ((m_k / m_P > 15) ? 15 : m_k / m_P) : 0;
    check("rx_sync", 32'(rx_sync), 32'(m_sync));
    check("edge_cnt", 32'(edge_cnt), 32'(exp_edge));
    check("bit_cnt", 32'(bit_cnt), 32'(exp_bit));
    check("sample_bit", 32'(smp_bit), 32'(m_bit));
    check("sample_valid", 32'(smp_vld), 32'(m_valid));
    if (smp_vld === 1'b1) begin
      obs_q.push_back(smp_bit);
      last_vld_edge = int'(edge_cnt);
    end
    if (int'(edge_cnt) > max_edge) max_edge = int'(edge_cnt);
    if (int'(bit_cnt) > max_bit) max_bit = int'(bit_cnt);
  endtask

  task automatic tick(input logic rx, input logic en, input logic [5:0] ps);
    rx_in    = rx;
    cnt_en   = en;
    prescale = ps;
    @(posedge clk);
    model_edge(rx, en, ps);
    #1;
    check_outputs();
  endtask

  task automatic clear_obs();
    obs_q.delete();
    last_vld_edge = -1;
    max_edge      = 0;
    max_bit       = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_sync"}, 32'(rx_sync), 32'd1);
    check({tag, "_edge"}, 32'(edge_cnt), 32'd0);
    check({tag, "_bit"}, 32'(bit_cnt), 32'd0);
    check({tag, "_smp"}, 32'(smp_bit), 32'd1);
    check({tag, "_vld"}, 32'(smp_vld), 32'd0);
  endtask

  initial begin
    logic [31:0] word;
    int          p, nb, abort_at, gap, len;
    logic [5:0]  ps;
    logic        bv, line;

    rst = 1'b1; rx_in = 1'b1; cnt_en = 1'b0; prescale = 6'd8;
    model_reset();
    clear_obs();
    #1;
    check_reset_values("por");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle.
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 6'd8);
    check("idle_max_edge", 32'(max_edge), 32'd0);
    check("idle_max_bit", 32'(max_bit), 32'd0);

    // P = 8, frame 0x55 with start and stop bits, LSB first.
    word = 32'h2AA;
    clear_obs();
    for (int j = 0; j < 10; j++)
      for (int t = 0; t < 8; t++) tick(word[j], 1'b1, 6'd8);
    check("f55_nsamples", 32'(obs_q.size()), 32'd10);
    for (int j = 0; j < 10 && j < obs_q.size(); j++)
      check($sformatf("f55_bit%0d", j), 32'(obs_q[j]), 32'(word[j]));
    check("f55_vld_edge", 32'(last_vld_edge), 32'd6);
    check("f55_max_bit", 32'(max_bit), 32'd9);
    tick(1'b1, 1'b0, 6'd8);

    // P = 16 glitch rejection: single low sample, then two low samples.
    clear_obs();
    for (int t = 0; t < 16; t++) tick(t != 7, 1'b1, 6'd16);
    for (int t = 0; t < 16; t++) tick(!(t == 6 || t == 7), 1'b1, 6'd16);
    check("glitch_nsamples", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      check("glitch_one_low", 32'(obs_q[0]), 32'd1);
      check("glitch_two_low", 32'(obs_q[1]), 32'd0);
    end
    tick(1'b1, 1'b0, 6'd16);

    // Mid-frame prescale change is ignored until the next frame.
    clear_obs();
    for (int t = 0; t < 8; t++) tick(1'b1, 1'b1, 6'd16);
    for (int t = 0; t < 40; t++) tick(1'b1, 1'b1, 6'd8);
    check("pchg_wrap16", 32'(max_edge), 32'd15);
    tick(1'b1, 1'b0, 6'd8);
    clear_obs();
    for (int t = 0; t < 24; t++) tick(1'b1, 1'b1, 6'd8);
    check("pchg_wrap8", 32'(max_edge), 32'd7);
    tick(1'b1, 1'b0, 6'd8);

    // Prescale below the minimum clamps to 8.
    clear_obs();
    for (int t = 0; t < 16; t++) tick(1'b0, 1'b1, 6'd4);
    check("clamp_vld_edge", 32'(last_vld_edge), 32'd6);
    check("clamp_wrap", 32'(max_edge), 32'd7);
    check("clamp_nsamples", 32'(obs_q.size()), 32'd2);
    // Fall and rise on consecutive edges.
    tick(1'b0, 1'b0, 6'd4);
    tick(1'b0, 1'b1, 6'd16);
    for (int t = 0; t < 20; t++) tick(1'b0, 1'b1, 6'd16);
    tick(1'b1, 1'b0, 6'd16);

    // Bit counter saturation over a long P = 8 frame.
    clear_obs();
    for (int t = 0; t < 18 * 8; t++) tick(1'b1, 1'b1, 6'd8);
    check("sat_max_bit", 32'(max_bit), 32'd15);
    tick(1'b1, 1'b0, 6'd8);

    // Asynchronous reset at edge 5 of bit 3, P = 32.
    clear_obs();
    tick(1'b0, 1'b1, 6'd32);
    while (m_k < 3 * 32 + 5) tick(1'($urandom_range(0, 1)), 1'b1, 6'd32);
    check("prerst_edge", 32'(edge_cnt), 32'd5);
    check("prerst_bit", 32'(bit_cnt), 32'd3);
    rst = 1'b1;
    #1;
    check_reset_values("rst_async");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_values("rst_held");
    rst = 1'b0;
    tick(1'b1, 1'b1, 6'd32);
    check("rst_restart_edge", 32'(edge_cnt), 32'd0);
    check("rst_restart_bit", 32'(bit_cnt), 32'd0);
    for (int t = 0; t < 40; t++) tick(1'b1, 1'b1, 6'd32);
    tick(1'b1, 1'b0, 6'd32);

    // Random frames, glitches, aborts and prescale changes.
    for (int f = 0; f < 30; f++) begin
      case ($urandom_range(0, 6))
        0: ps = 6'd8;
        1: ps = 6'd16;
        2: ps = 6'd32;
        3: ps = 6'd4;
        4: ps = 6'd9;
        5: ps = 6'd13;
        default: ps = 6'd0;
      endcase
      p        = clamp_p(ps);
      nb       = $urandom_range(1, 12);
      len      = nb * p;
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : -1;
      bv       = 1'b1;
      for (int t = 0; t < len; t++) begin
        if (t == abort_at) break;
        if (t % p == 0) bv = 1'($urandom_range(0, 1));
        line = bv ^ ($urandom_range(0, 9) == 0);
        tick(line, 1'b1, (t == 0) ? ps : 6'($urandom_range(0, 63)));
      end
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) tick(1'b1, 1'b0, 6'($urandom_range(0, 63)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_data_sampler_rx

// File: doc/data_sampler_rx.md
# data_sampler_rx

Bit-timing and sampling front end of the UART receive path. It synchronises the raw serial line, runs the oversampling edge counter and the bit counter, and takes a 3-sample majority vote around each bit centre. It sits directly upstream of the RX deserializer and the parity/stop checkers. It supplies `edge_cnt`, `bit_cnt` and the voted bit, which the deserializer shifts in at `edge_cnt == prescale-1`.

## Interface
- `PRESCALE_W`, 6: width of the prescale and edge counter.
- `BIT_CNT_W`, 4: width of the bit counter; a frame is at most 11 bits.
- `CLK_smp`  in  1  RX oversampling clock, prescale × baud.
- `RST_smp`  in  1  Asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `RX_IN_smp`  in  1  Raw serial line; asynchronous, idles high.
- `cnt_en`  in  1  Count/sample enable from the RX FSM; high for the duration of a frame.
- `prescale_FSM`  in  PRESCALE_W  Oversampling ratio. Legal values are 8, 16 and 32.
- `rx_sync`  out  1  Synchronised line, used by the FSM for start-bit detection.
- `edge_cnt`  out  PRESCALE_W  Edge position within the current bit, 0..P-1.
- `bit_cnt`  out  BIT_CNT_W  Index of the current bit within the frame.
- `sample_bit_deser`  out  1  Majority-voted value of the current bit.
- `sample_valid`  out  1  One-cycle pulse when `sample_bit_deser` updates.

## Operation
- Synchroniser: 2-FF chain on `RX_IN_smp` drives `rx_sync`.
- Two-state FSM, IDLE and COUNT:
  - IDLE→COUNT when `cnt_en` is high.
  - COUNT→IDLE when `cnt_en` is low.
  - On the IDLE→COUNT transition, the block latches `prescale_FSM` into internal `P`.
  - `P` holds for the whole frame; changes to `prescale_FSM` mid-frame are ignored.
- Prescale clamp: if the latched value is below 8, `P` = 8. Odd values are used as given; the half point is `H = P>>1` (floor).
- In IDLE: `edge_cnt` = 0, `bit_cnt` = 0, `sample_valid` = 0. `sample_bit_deser` holds its value.
- In COUNT, `edge_cnt` increments each cycle.
  - At `edge_cnt == P-1`, `edge_cnt` wraps to 0 and `bit_cnt` increments.
  - `bit_cnt` saturates at 2^BIT_CNT_W−1 and never wraps.
- Sampling in COUNT:
  - `s0` ← `rx_sync` when `edge_cnt == H-1`.
  - `s1` ← `rx_sync` when `edge_cnt == H`.
  - When `edge_cnt == H+1`: `sample_bit_deser` ← majority(`s0`, `s1`, `rx_sync`), and `sample_valid` ← 1 for one cycle.
- Arithmetic: compare constants are computed at PRESCALE_W+1 bits, so no wrap occurs for P = 32.
- `cnt_en` dropping mid-bit aborts counting on the next edge. No sample is produced for the partial bit.

## Timing
- Reset values:
  - `rx_sync` = 1, and both synchroniser flops = 1.
  - `edge_cnt` = 0, `bit_cnt` = 0.
  - `sample_bit_deser` = 1, `sample_valid` = 0.
  - `s0` = `s1` = 1; FSM in IDLE.
- `RX_IN_smp` → `rx_sync` latency: 2 cycles.
- The first COUNT cycle presents `edge_cnt` = 0, one cycle after `cnt_en` is sampled high.
- `sample_bit_deser` is stable from the cycle where `edge_cnt == H+2` through `edge_cnt == P-1` of the same bit.
  - This guarantees a setup margin of at least 1 cycle before the deserializer shift at P-1, for P ≥ 8.
- `sample_valid` is high exactly in the `edge_cnt == H+2` cycle.
- If `cnt_en` falls and rises again on consecutive cycles, the block passes through IDLE for one cycle: counters clear, and the new `P` is latched.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronously). No `sample_valid` is emitted.

## Structure
- Shared package `uart_rx_pkg` holds:
  - `PRESCALE_W` and `BIT_CNT_W` defaults.
  - Legal prescale constants (`PRESC_8`, `PRESC_16`, `PRESC_32`) and `PRESC_MIN` = 8.
  - A `maj3` function.
  - The FSM state typedef.
- One sub-module, `bit_sync_2ff`, a reusable 2-flop synchroniser with a parameterised reset value. It is instantiated once here.

## Test plan
- Reset then idle: `RX_IN_smp` = 1 and `cnt_en` = 0 → all outputs at reset values, `edge_cnt` and `bit_cnt` stay 0.
- P = 8, frame 0x55 (start, 8 data bits LSB-first, stop), `cnt_en` held for 10 bits:
  - Expected sequence: `sample_valid` pulses at `edge_cnt` = 6 of each bit.
  - Expected values: voted bits 0,1,0,1,0,1,0,1,0,1.
  - Expected counter: `bit_cnt` reaches 9.
- P = 16, one-cycle glitch to 0 at `edge_cnt` = 8 inside a '1' bit → `sample_bit_deser` = 1.
  - Two low samples at `edge_cnt` 7 and 8 → 0.
- Change `prescale_FSM` from 16 to 8 mid-frame → `edge_cnt` still wraps at 15 until `cnt_en` drops. The next frame wraps at 7.
- `prescale_FSM` = 4 → behaves as P = 8, with `sample_valid` at `edge_cnt` = 6.
- Assert `RST_smp` at `edge_cnt` = 5 of bit 3, P = 32 → all outputs return to reset values in the same cycle, with no `sample_valid` pulse.
  - After release with `cnt_en` high, counting restarts at `edge_cnt` = 0 and `bit_cnt` = 0.
